// File: rtl/alu_uart_host_if.sv
// Host-side request/response bundle for alu_uart_host: operands and opcode in,
// result and status pulses out.
interface alu_uart_host_if #(
   parameter int unsigned N_BIT = 8
);
   logic             start;
   logic [N_BIT-1:0] a;
   logic [N_BIT-1:0] b;
   logic [N_BIT-1:0] op;
   logic             busy;
   logic [N_BIT-1:0] result;
   logic             done;
   logic             err_timeout;
   logic             err_frame;

   modport master (
      output start, a, b, op,
      input  busy, result, done, err_timeout, err_frame
   );

   modport slave (
      input  start, a, b, op,
      output busy, result, done, err_timeout, err_frame
   );
endinterface

// File: rtl/alu_uart_host.sv
// Host peer of the UART ALU link: sends A, B and opcode as 8N1 frames, then
// waits for a one-byte result frame with a tick-based timeout.
module alu_uart_host #(
   parameter int unsigned N_BIT         = 8,
   parameter int unsigned N_TICK        = 16,
   parameter int unsigned DVSR          = 163,
   parameter int unsigned DVSR_BIT      = 8,
   parameter int unsigned TIMEOUT_TICKS = 4096,
   parameter int unsigned TO_BIT        = 13
) (
   input  logic           CLK,
   input  logic           RESET,
   alu_uart_host_if.slave host,
   input  logic           rx,
   output logic           tx
);
   localparam int unsigned S_BIT = $clog2(N_TICK);
   localparam int unsigned C_BIT = $clog2(N_BIT);

   typedef enum logic [2:0] {SEQ_IDLE, SEQ_SEND_A, SEQ_SEND_B, SEQ_SEND_OP, SEQ_WAIT_RES} seq_e;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_e;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_e;

   seq_e                seq_q, seq_d;
   tx_e                 tx_state_q, tx_state_d;
   rx_e                 rx_state_q, rx_state_d;
   logic [DVSR_BIT-1:0] cnt_q, cnt_d;
   logic [N_BIT-1:0]    a_q, a_d, b_q, b_d, op_q, op_d, result_q, result_d;
   logic [N_BIT-1:0]    tx_b_q, tx_b_d, rx_b_q, rx_b_d, tx_byte;
   logic [S_BIT-1:0]    tx_s_q, tx_s_d, rx_s_q, rx_s_d;
   logic [C_BIT-1:0]    tx_n_q, tx_n_d, rx_n_q, rx_n_d;
   logic [TO_BIT-1:0]   to_q, to_d;
   logic                tx_q, tx_d, rx_meta_q, rx_sync_q;
   logic                busy_q, busy_d, done_q, done_d;
   logic                err_timeout_q, err_timeout_d, err_frame_q, err_frame_d;
   logic                tick, tx_start, tx_done, rx_done, rx_ok;

   always_comb begin
      tick  = (cnt_q == DVSR_BIT'(DVSR - 1));
      cnt_d = tick ? '0 : cnt_q + 1'b1;
   end

   // Serialiser; tx_d follows the next state so the line changes with the state register.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_s_d     = tx_s_q;
      tx_n_d     = tx_n_q;
      tx_b_d     = tx_b_q;
      tx_done    = 1'b0;
      tx_start   = (seq_q inside {SEQ_SEND_A, SEQ_SEND_B, SEQ_SEND_OP}) && (tx_state_q == TX_IDLE);
      case (seq_q)
         SEQ_SEND_A: tx_byte = a_q;
         SEQ_SEND_B: tx_byte = b_q;
         default:    tx_byte = op_q;
      endcase
      case (tx_state_q)
         TX_IDLE: if (tx_start) begin
            tx_state_d = TX_START;
            tx_s_d     = '0;
            tx_b_d     = tx_byte;
         end
         TX_START: if (tick) begin
            if (tx_s_q == S_BIT'(N_TICK - 1)) begin
               tx_state_d = TX_DATA;
               tx_s_d     = '0;
               tx_n_d     = '0;
            end else tx_s_d = tx_s_q + 1'b1;
         end
         TX_DATA: if (tick) begin
            if (tx_s_q == S_BIT'(N_TICK - 1)) begin
               tx_s_d = '0;
               tx_b_d = tx_b_q >> 1;
               if (tx_n_q == C_BIT'(N_BIT - 1)) tx_state_d = TX_STOP;
               else tx_n_d = tx_n_q + 1'b1;
            end else tx_s_d = tx_s_q + 1'b1;
         end
         default: if (tick) begin
            if (tx_s_q == S_BIT'(N_TICK - 1)) begin
               tx_state_d = TX_IDLE;
               tx_done    = 1'b1;
            end else tx_s_d = tx_s_q + 1'b1;
         end
      endcase
      case (tx_state_d)
         TX_START: tx_d = 1'b0;
         TX_DATA:  tx_d = tx_b_d[0];
         default:  tx_d = 1'b1;
      endcase
   end

   // Deserialiser: start bit confirmed at mid-bit, then one sample per bit period.
   always_comb begin
      rx_state_d = rx_state_q;
      rx_s_d     = rx_s_q;
      rx_n_d     = rx_n_q;
      rx_b_d     = rx_b_q;
      rx_done    = 1'b0;
      rx_ok      = 1'b0;
      case (rx_state_q)
         RX_IDLE: if (!rx_sync_q) begin
            rx_state_d = RX_START;
            rx_s_d     = '0;
         end
         RX_START: if (tick) begin
            if (rx_s_q == S_BIT'(N_TICK / 2 - 1)) begin
               rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
               rx_s_d     = '0;
               rx_n_d     = '0;
            end else rx_s_d = rx_s_q + 1'b1;
         end
         RX_DATA: if (tick) begin
            if (rx_s_q == S_BIT'(N_TICK - 1)) begin
               rx_s_d = '0;
               rx_b_d = {rx_sync_q, rx_b_q[N_BIT-1:1]};
               if (rx_n_q == C_BIT'(N_BIT - 1)) rx_state_d = RX_STOP;
               else rx_n_d = rx_n_q + 1'b1;
            end else rx_s_d = rx_s_q + 1'b1;
         end
         default: if (tick) begin
            if (rx_s_q == S_BIT'(N_TICK - 1)) begin
               rx_state_d = RX_IDLE;
               rx_done    = 1'b1;
               rx_ok      = rx_sync_q;
            end else rx_s_d = rx_s_q + 1'b1;
         end
      endcase
   end

   always_comb begin
      seq_d         = seq_q;
      a_d           = a_q;
      b_d           = b_q;
      op_d          = op_q;
      to_d          = to_q;
      result_d      = result_q;
      done_d        = 1'b0;
      err_frame_d   = 1'b0;
      err_timeout_d = 1'b0;
      case (seq_q)
         SEQ_IDLE: if (host.start) begin
            a_d   = host.a;
            b_d   = host.b;
            op_d  = host.op;
            seq_d = SEQ_SEND_A;
         end
         SEQ_SEND_A: if (tx_done) seq_d = SEQ_SEND_B;
         SEQ_SEND_B: if (tx_done) seq_d = SEQ_SEND_OP;
         SEQ_SEND_OP: if (tx_done) begin
            seq_d = SEQ_WAIT_RES;
            to_d  = '0;
         end
         default: begin
            // Timeout only advances while the receiver is idle, so a frame in flight holds it.
            if (rx_done) begin
               seq_d = SEQ_IDLE;
               if (rx_ok) begin
                  result_d = rx_b_q;
                  done_d   = 1'b1;
               end else err_frame_d = 1'b1;
            end else if (rx_state_q == RX_IDLE && tick) begin
               if (to_q == TO_BIT'(TIMEOUT_TICKS - 1)) begin
                  seq_d         = SEQ_IDLE;
                  err_timeout_d = 1'b1;
               end else to_d = to_q + 1'b1;
            end
         end
      endcase
      busy_d = (seq_d != SEQ_IDLE);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         seq_q         <= SEQ_IDLE;
         tx_state_q    <= TX_IDLE;
         rx_state_q    <= RX_IDLE;
         cnt_q         <= '0;
         a_q           <= '0;
         b_q           <= '0;
         op_q          <= '0;
         result_q      <= '0;
         tx_b_q        <= '0;
         rx_b_q        <= '0;
         tx_s_q        <= '0;
         rx_s_q        <= '0;
         tx_n_q        <= '0;
         rx_n_q        <= '0;
         to_q          <= '0;
         tx_q          <= 1'b1;
         rx_meta_q     <= 1'b1;
         rx_sync_q     <= 1'b1;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         err_timeout_q <= 1'b0;
         err_frame_q   <= 1'b0;
      end else begin
         seq_q         <= seq_d;
         tx_state_q    <= tx_state_d;
         rx_state_q    <= rx_state_d;
         cnt_q         <= cnt_d;
         a_q           <= a_d;
         b_q           <= b_d;
         op_q          <= op_d;
         result_q      <= result_d;
         tx_b_q        <= tx_b_d;
         rx_b_q        <= rx_b_d;
         tx_s_q        <= tx_s_d;
         rx_s_q        <= rx_s_d;
         tx_n_q        <= tx_n_d;
         rx_n_q        <= rx_n_d;
         to_q          <= to_d;
         tx_q          <= tx_d;
         rx_meta_q     <= rx;
         rx_sync_q     <= rx_meta_q;
         busy_q        <= busy_d;
         done_q        <= done_d;
         err_timeout_q <= err_timeout_d;
         err_frame_q   <= err_frame_d;
      end
   end

   assign tx               = tx_q;
   assign host.busy        = busy_q;
   assign host.result      = result_q;
   assign host.done        = done_q;
   assign host.err_timeout = err_timeout_q;
   assign host.err_frame   = err_frame_q;
endmodule
